// File: rtl/psone_pkg.sv
// Shared constants and FSM encoding for the PlayStation pad responder.
// PSONE_ANALOG_EN selects the analog ID and the 9-byte frame.
package psone_pkg;

    localparam logic [7:0] CMD_START  = 8'h01;
    localparam logic [7:0] CMD_POLL   = 8'h42;
    localparam logic [7:0] ID_DIGITAL = 8'h41;
    localparam logic [7:0] ID_ANALOG  = 8'h73;
    localparam logic [7:0] PAD_MARK   = 8'h5A;
    localparam logic [7:0] IDLE_BYTE  = 8'hFF;

`ifdef PSONE_ANALOG_EN
    localparam logic [7:0] PAD_ID   = ID_ANALOG;
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [7:0] PAD_ID   = ID_DIGITAL;
    localparam logic [3:0] LAST_IDX = 4'd4;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ACK_WAIT,
        ST_ACK_PULSE,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/psone_sync.sv
// Two-flop synchronizer with a registered edge detector.
module psone_sync
    import psone_pkg::*;
#(
    parameter logic INIT = 1'b1
) (
    input  logic iCLK,
    input  logic iRESET,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            s1 <= INIT;
            s2 <= INIT;
            s3 <= INIT;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign lvl  = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/psone_pad_dev.sv
// Pad-side responder for the PlayStation ATT/CLK/CMD/DAT/ACK link.
// Define PSONE_ANALOG_EN for analog mode (ID 0x73, iAXIS, 9-byte frame).
module psone_pad_dev
    import psone_pkg::*;
#(
    parameter int ACK_DELAY = 150,
    parameter int ACK_WIDTH = 100
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iCS,
    input  logic        iSCK,
    input  logic        iMOSI,
    input  logic [15:0] iBTN,
`ifdef PSONE_ANALOG_EN
    input  logic [31:0] iAXIS,
`endif
    output logic        oMISO,
    output logic        oACK,
    output logic        oFRAME_DONE
);

    logic cs_lvl, cs_rise, cs_fall;
    logic sck_lvl, sck_rise_raw, sck_fall_raw;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic sck_rise, sck_fall;

    psone_sync #(.INIT(1'b1)) u_cs (
        .iCLK(iCLK), .iRESET(iRESET), .d(iCS),
        .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    psone_sync #(.INIT(1'b1)) u_sck (
        .iCLK(iCLK), .iRESET(iRESET), .d(iSCK),
        .lvl(sck_lvl), .rise(sck_rise_raw), .fall(sck_fall_raw)
    );

    psone_sync #(.INIT(1'b1)) u_mosi (
        .iCLK(iCLK), .iRESET(iRESET), .d(iMOSI),
        .lvl(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = sck_lvl ^ mosi_rise ^ mosi_fall;

    // Clock edges only count while ATT is held low
    assign sck_rise = sck_rise_raw & ~cs_lvl;
    assign sck_fall = sck_fall_raw & ~cs_lvl;

    state_t      state;
    logic [3:0]  byte_idx;
    logic [2:0]  bit_cnt;
    logic [7:0]  tx;
    logic [7:0]  rx;
    logic [15:0] cnt;
    logic [15:0] btn_q;
`ifdef PSONE_ANALOG_EN
    logic [31:0] axis_q;
`endif

    logic [3:0] nidx;
    logic [7:0] next_tx;
    logic [7:0] rx_n;

    assign nidx = byte_idx + 4'd1;
    assign rx_n = {mosi_lvl, rx[7:1]};

    always_comb begin
        next_tx = IDLE_BYTE;
        case (nidx)
            4'd1: next_tx = PAD_ID;
            4'd2: next_tx = PAD_MARK;
            4'd3: next_tx = ~btn_q[7:0];
            4'd4: next_tx = ~btn_q[15:8];
`ifdef PSONE_ANALOG_EN
            4'd5: next_tx = axis_q[7:0];
            4'd6: next_tx = axis_q[15:8];
            4'd7: next_tx = axis_q[23:16];
            4'd8: next_tx = axis_q[31:24];
`endif
            default: next_tx = IDLE_BYTE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state       <= ST_IDLE;
            byte_idx    <= 4'd0;
            bit_cnt     <= 3'd0;
            tx          <= IDLE_BYTE;
            rx          <= 8'd0;
            cnt         <= 16'd0;
            btn_q       <= 16'd0;
`ifdef PSONE_ANALOG_EN
            axis_q      <= 32'd0;
`endif
            oMISO       <= 1'b1;
            oACK        <= 1'b1;
            oFRAME_DONE <= 1'b0;
        end else begin
            oFRAME_DONE <= 1'b0;
            if (cs_rise) begin
                state    <= ST_IDLE;
                byte_idx <= 4'd0;
                bit_cnt  <= 3'd0;
                cnt      <= 16'd0;
                oMISO    <= 1'b1;
                oACK     <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            byte_idx <= 4'd0;
                            bit_cnt  <= 3'd0;
                            tx       <= IDLE_BYTE;
                            btn_q    <= iBTN;
`ifdef PSONE_ANALOG_EN
                            axis_q   <= iAXIS;
`endif
                            state    <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (sck_fall) begin
                            oMISO <= tx[0];
                            tx    <= {1'b1, tx[7:1]};
                        end
                        if (sck_rise) begin
                            rx      <= rx_n;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if ((byte_idx == 4'd0 && rx_n != CMD_START) ||
                                    (byte_idx == 4'd1 && rx_n != CMD_POLL)) begin
                                    state <= ST_IGNORE;
                                    oMISO <= 1'b1;
                                end else if (byte_idx == LAST_IDX) begin
                                    oFRAME_DONE <= 1'b1;
                                    state       <= ST_IGNORE;
                                    oMISO       <= 1'b1;
                                end else begin
                                    cnt   <= 16'd0;
                                    state <= ST_ACK_WAIT;
                                end
                            end
                        end
                    end
                    ST_ACK_WAIT: begin
                        if (cnt == 16'(ACK_DELAY - 1)) begin
                            cnt   <= 16'd0;
                            oACK  <= 1'b0;
                            state <= ST_ACK_PULSE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    ST_ACK_PULSE: begin
                        if (cnt == 16'(ACK_WIDTH - 1)) begin
                            cnt      <= 16'd0;
                            oACK     <= 1'b1;
                            byte_idx <= nidx;
                            tx       <= next_tx;
                            state    <= ST_SHIFT;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    ST_IGNORE: begin
                        oMISO <= 1'b1;
                        oACK  <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psone_pad_dev.sv
// Scoreboard bench for psone_pad_dev acting as a host poller.
// Define PSONE_ANALOG_EN to exercise the analog frame.
module tb_psone_pad_dev;

    localparam int H = 8;
    localparam int D = 150;
    localparam int W = 100;
    localparam int BUDGET = D + W + 100;
`ifdef PSONE_ANALOG_EN
    localparam int NB = 9;
    localparam logic [7:0] EXP_ID = 8'h73;
`else
    localparam int NB = 5;
    localparam logic [7:0] EXP_ID = 8'h41;
`endif

    logic        clk;
    logic        rst_n;
    logic        cs;
    logic        sck;
    logic        mosi;
    logic [15:0] btn;
    logic [31:0] axis;
    logic        miso;
    logic        ack;
    logic        fdone;

    int vectors;
    int miscompares;
    int ack_falls;
    int fd_cnt;
    logic ack_prev;
    logic [7:0] sb[$];

    psone_pad_dev #(.ACK_DELAY(D), .ACK_WIDTH(W)) dut (
        .iCLK(clk),
        .iRESET(rst_n),
        .iCS(cs),
        .iSCK(sck),
        .iMOSI(mosi),
        .iBTN(btn),
`ifdef PSONE_ANALOG_EN
        .iAXIS(axis),
`endif
        .oMISO(miso),
        .oACK(ack),
        .oFRAME_DONE(fdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        ack_falls = 0;
        fd_cnt = 0;
        ack_prev = 1'b1;
    end

    always @(negedge clk) begin
        if (ack_prev === 1'b1 && ack === 1'b0) ack_falls++;
        ack_prev = ack;
        if (fdone === 1'b1) fd_cnt++;
    end

    function automatic logic [7:0] exp_byte(input int idx, input logic [15:0] b,
                                            input logic [31:0] ax);
        case (idx)
            0: return 8'hFF;
            1: return EXP_ID;
            2: return 8'h5A;
            3: return ~b[7:0];
            4: return ~b[15:8];
            5: return ax[7:0];
            6: return ax[15:8];
            7: return ax[23:16];
            8: return ax[31:24];
            default: return 8'hFF;
        endcase
    endfunction

    task automatic xfer(input logic [7:0] c, output logic [7:0] r);
        for (int i = 0; i < 8; i++) begin
            sck = 1'b0;
            mosi = c[i];
            repeat (H) @(negedge clk);
            r[i] = miso;
            sck = 1'b1;
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic wait_ack(output int w);
        int t;
        t = 0;
        w = 0;
        while (ack === 1'b1 && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        if (ack !== 1'b0) begin
            w = -1;
            return;
        end
        while (ack === 1'b0 && w < BUDGET) begin
            w++;
            @(negedge clk);
        end
    endtask

    task automatic check_byte(input int idx, input logic [7:0] got);
        logic [7:0] e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL dat[%0d]: got %h, scoreboard empty", idx, got);
            return;
        end
        e = sb.pop_front();
        if (got !== e) begin
            miscompares++;
            $display("FAIL dat[%0d]: got %h expected %h", idx, got, e);
        end
    endtask

    task automatic poll(input logic [15:0] b, input logic [7:0] c0,
                        input int chg_byte, input logic [15:0] chg_btn);
        logic [7:0] c;
        logic [7:0] r;
        int a0;
        int f0;
        int w;
        bit good;
        good = (c0 == 8'h01);
        btn = b;
        a0 = ack_falls;
        f0 = fd_cnt;
        for (int i = 0; i < NB; i++)
            sb.push_back(good ? exp_byte(i, b, axis) : 8'hFF);
        cs = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            if (i == chg_byte) btn = chg_btn;
            c = (i == 0) ? c0 : ((i == 1) ? 8'h42 : 8'h00);
            xfer(c, r);
            check_byte(i, r);
            if (i < NB - 1) begin
                if (good) begin
                    wait_ack(w);
                    vectors++;
                    if (w != W) begin
                        miscompares++;
                        $display("FAIL ack_width[%0d]: got %0d expected %0d", i, w, W);
                    end
                end else begin
                    repeat (D + W + 10) @(negedge clk);
                end
            end
        end
        repeat (20) @(negedge clk);
        cs = 1'b1;
        repeat (H) @(negedge clk);
        vectors++;
        if (ack_falls - a0 != (good ? NB - 1 : 0)) begin
            miscompares++;
            $display("FAIL ack_count: got %0d expected %0d", ack_falls - a0,
                     good ? NB - 1 : 0);
        end
        vectors++;
        if (fd_cnt - f0 != (good ? 1 : 0)) begin
            miscompares++;
            $display("FAIL frame_done: got %0d expected %0d", fd_cnt - f0, good ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cs = 1'b1;
        sck = 1'b1;
        mosi = 1'b1;
        btn = 16'h0;
        axis = 32'h807F00FF;
        repeat (4) @(negedge clk);
        vectors += 3;
        if (miso !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_miso: got %b expected 1", miso);
        end
        if (ack !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ack: got %b expected 1", ack);
        end
        if (fdone !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fdone: got %b expected 0", fdone);
        end
        rst_n = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic test_poll();
        poll(16'h0009, 8'h01, -1, 16'h0);
    endtask

    task automatic test_bad_start();
        poll(16'h0009, 8'h81, -1, 16'h0);
    endtask

    task automatic test_cs_abort();
        logic [7:0] r;
        int w;
        int f0;
        btn = 16'h1234;
        f0 = fd_cnt;
        sb.push_back(8'hFF);
        sb.push_back(EXP_ID);
        cs = 1'b0;
        repeat (H) @(negedge clk);
        xfer(8'h01, r);
        check_byte(0, r);
        wait_ack(w);
        xfer(8'h42, r);
        check_byte(1, r);
        wait_ack(w);
        for (int i = 0; i < 3; i++) begin
            sck = 1'b0;
            mosi = 1'b0;
            repeat (H) @(negedge clk);
            sck = 1'b1;
            repeat (H) @(negedge clk);
        end
        vectors++;
        if (miso !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_pre_miso: got %b expected 0", miso);
        end
        cs = 1'b1;
        repeat (4) @(negedge clk);
        vectors += 3;
        if (miso !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_miso: got %b expected 1", miso);
        end
        if (ack !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_ack: got %b expected 1", ack);
        end
        repeat (H) @(negedge clk);
        if (fd_cnt != f0) begin
            miscompares++;
            $display("FAIL abort_fdone: got %0d expected 0", fd_cnt - f0);
        end
        poll(16'h0009, 8'h01, -1, 16'h0);
    endtask

    task automatic test_snapshot();
        poll(16'h0000, 8'h01, 2, 16'hFFFF);
        poll(16'hFFFF, 8'h01, -1, 16'h0);
    endtask

    task automatic test_reset_in_ack();
        logic [7:0] r;
        int t;
        btn = 16'h0009;
        cs = 1'b0;
        repeat (H) @(negedge clk);
        xfer(8'h01, r);
        t = 0;
        while (ack === 1'b1 && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_ack_seen: got %b expected 0", ack);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors += 3;
        if (ack !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_async_ack: got %b expected 1", ack);
        end
        if (miso !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_async_miso: got %b expected 1", miso);
        end
        if (fdone !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async_fdone: got %b expected 0", fdone);
        end
        repeat (3) @(negedge clk);
        cs = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (H) @(negedge clk);
        poll(16'h8001, 8'h01, -1, 16'h0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_poll();
        test_bad_start();
        test_cs_abort();
        test_snapshot();
        test_reset_in_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/psone_pad_dev.md
# psone_pad_dev

Controller-side responder for the PlayStation pad serial link. It emulates a digital (or, optionally, analog) pad on the ATT/CLK/CMD/DAT/ACK bus. It receives the host's command bytes LSB-first and returns the ID, the 0x5A marker and the button bytes, with an ACK pulse after every byte except the last. It sits between the board's button inputs and the pad connector, and pairs with the existing host-side poller for loopback testing on a single FPGA.

## Interface
Parameters:
- ACK_DELAY, 150: iCLK cycles from the 8th rising SCK edge to the start of the ACK pulse.
- ACK_WIDTH, 100: iCLK cycles that oACK is held low.

Ports:
- iCLK  in  1  system clock; single clock domain.
- iRESET  in  1  asynchronous, active-low reset.
- iCS  in  1  ATT from the host, active low, asynchronous.
- iSCK  in  1  host serial clock, idle high, asynchronous.
- iMOSI  in  1  CMD line, asynchronous.
- iBTN  in  16  pressed = 1. Bits [7:0] are SELECT, L3, R3, START, UP, RIGHT, DOWN, LEFT. Bits [15:8] are L2, R2, L1, R1, TRI, CIR, CROSS, SQR.
- iAXIS  in  32  {LY, LX, RY, RX}; present only with PSONE_ANALOG_EN.
- oMISO  out  1  DAT line; idle 1.
- oACK  out  1  ACK line, active low; idle 1.
- oFRAME_DONE  out  1  one-cycle pulse when a complete poll has been served.

## Operation
- iCS, iSCK and iMOSI each pass through a 2-flop synchronizer, then a registered edge detector.
- Snapshot on iCS fall: iBTN (and iAXIS) are latched. All reply bytes in the frame come from this snapshot.
- Reply sequence:
  - Byte 0: 0xFF.
  - Byte 1: ID (0x41 digital, 0x73 analog).
  - Byte 2: 0x5A.
  - Byte 3: ~btn[7:0].
  - Byte 4: ~btn[15:8].
  - Analog mode adds bytes 5..8: RX, RY, LX, LY (not inverted).
- The last byte index is 4 in digital mode and 8 in analog mode.
- On a SCK falling edge, oMISO drives tx[0] and tx shifts right.
- On a SCK rising edge, rx becomes {mosi, rx[7:1]} and bit_cnt increments (3 bits; it wraps to 0 after 8).
- States:
  - IDLE: wait for CS fall. Then byte_idx=0, tx=0xFF, go to SHIFT.
  - SHIFT: after the 8th rising edge, check the received byte:
    - byte 0 must be 0x01 and byte 1 must be 0x42, otherwise go to IGNORE;
    - if byte_idx equals the last index, pulse oFRAME_DONE and go to IGNORE;
    - otherwise go to ACK_WAIT.
  - ACK_WAIT: count ACK_DELAY cycles, then go to ACK_PULSE.
  - ACK_PULSE: oACK=0 for ACK_WIDTH cycles. Then byte_idx increments, tx loads the next reply byte, and the FSM returns to SHIFT.
  - IGNORE: oMISO=1, oACK=1; wait for CS to rise.
- CS rise in any state forces IDLE on the next cycle: oMISO=1, oACK=1, counters cleared, no oFRAME_DONE. Bytes already shifted are discarded.
- SCK edges seen during ACK_WAIT or ACK_PULSE are ignored; bit_cnt stays 0.
- When a SCK edge and a CS rise are detected on the same cycle, the CS rise wins.

## Timing
- Reset values: oMISO=1, oACK=1, oFRAME_DONE=0, state IDLE, all counters 0.
- Pin-to-action latency: 3 iCLK cycles (2 sync stages plus the edge register).
  - oMISO updates 3 cycles after a SCK fall at the pin.
  - A sample is taken 3 cycles after a SCK rise.
- oACK falls exactly ACK_DELAY+1 cycles after the rising-edge detect of bit 7, and stays low exactly ACK_WIDTH cycles.
- The next tx byte is loaded on the cycle oACK returns high. The first bit of that byte appears on the following SCK fall.
- oFRAME_DONE asserts on the cycle after the last byte's 8th rising-edge detect.
- The host half-period must be at least 4 iCLK cycles. No behaviour is defined for faster SCK.
- Asserting reset mid-frame returns every output to its reset value immediately (asynchronously).

## Configuration
- PSONE_ANALOG_EN defined:
  - ID is 0x73;
  - the iAXIS port exists;
  - frame length is 9 bytes, with ACK after bytes 0..7.
- Undefined:
  - ID is 0x41;
  - no iAXIS port;
  - frame length is 5 bytes, with ACK after bytes 0..3.

## Structure
- psone_pkg holds the constants:
  - CMD_START=0x01, CMD_POLL=0x42;
  - ID_DIGITAL=0x41, ID_ANALOG=0x73;
  - PAD_MARK=0x5A, IDLE_BYTE=0xFF;
  - the FSM state encoding.
- Sub-module psone_sync: a 2-flop synchronizer plus rise/fall pulse outputs. It is instantiated three times, once each for CS, SCK and MOSI.
- The reply-byte mux (byte_idx to tx value) stays inside psone_pad_dev.

## Test plan
- Digital poll with iBTN=0x0009 (SELECT, START pressed):
  - host sends 01 42 00 00 00;
  - DAT returns FF 41 5A F6 FF;
  - 4 ACK pulses, each ACK_WIDTH cycles long;
  - oFRAME_DONE pulses once.
- Bad start byte (host sends 0x81):
  - DAT returns FF, then stays 1;
  - no ACK for the rest of the frame;
  - no oFRAME_DONE.
- CS rises mid-byte 2:
  - oMISO=1 and oACK=1 within 4 cycles;
  - the next full poll returns the correct bytes.
- iBTN changes mid-frame from 0x0000 to 0xFFFF:
  - bytes 3 and 4 still return FF FF (snapshot);
  - the next frame returns 00 00.
- With PSONE_ANALOG_EN and iAXIS=0x80_7F_00_FF:
  - DAT returns FF 73 5A btn btn FF 00 7F 80;
  - 8 ACK pulses.
- Reset asserted during ACK_PULSE:
  - oACK is 1 immediately;
  - state is IDLE after reset is released.
